// File: rtl/fc_layer_mac.sv
// Sequential fully-connected layer: one fixed-point MAC per cycle per output neuron, weights/biases streamed from a 1-cycle-latency memory.
// Optional build macro FC_RELU_EN clamps negative saturated results to zero before they are written.
module fc_layer_mac #(
  parameter int SIZE   = 16,
  parameter int FRAC   = 8,
  parameter int IN_SZ  = 120,
  parameter int OUT_SZ = 84,
  parameter int ACC_W  = 40,
  localparam int AW    = $clog2(OUT_SZ * (IN_SZ + 1))
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [0:IN_SZ-1][SIZE-1:0]  in_values,
  output logic [AW-1:0]               weight_addr,
  input  logic [SIZE-1:0]             weight_data,
  output logic                        busy,
  output logic                        done,
  output logic                        out_load_en,
  output logic [SIZE-1:0]             out_load_address,
  output logic [SIZE-1:0]             out_load_value
);

  localparam int IW = $clog2(IN_SZ + 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (SIZE - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(2 ** (SIZE - 1));

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAC   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                    state_r, state_next_s;
  logic [IW-1:0]             i_r, rd_idx_r;
  logic                      rd_valid_r;
  logic [SIZE-1:0]           o_r;
  logic signed [ACC_W-1:0]   acc_r, acc_next_s;
  logic signed [SIZE-1:0]    in_sel_s;
  logic signed [2*SIZE-1:0]  prod_s;
  logic [AW-1:0]             weight_addr_r;
  logic                      busy_r, done_r, load_en_r;
  logic [SIZE-1:0]           load_addr_r, load_value_r;

  // Shift, saturate and (optionally) rectify an accumulator into a data word.
  function automatic logic [SIZE-1:0] to_out(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    logic [SIZE-1:0]         res;
    r = a >>> FRAC;
    if (r > SAT_MAX) begin
      res = SAT_MAX[SIZE-1:0];
    end else if (r < SAT_MIN) begin
      res = SAT_MIN[SIZE-1:0];
    end else begin
      res = r[SIZE-1:0];
    end
`ifdef FC_RELU_EN
    if (res[SIZE-1]) begin
      res = {SIZE{1'b0}};
    end else begin
      res = res;
    end
`endif
    return res;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  if (start) state_next_s = ST_MAC; else state_next_s = ST_IDLE;
      ST_MAC:   if (i_r == IW'(IN_SZ)) state_next_s = ST_DRAIN; else state_next_s = ST_MAC;
      ST_DRAIN: state_next_s = ST_WRITE;
      ST_WRITE: if (o_r == SIZE'(OUT_SZ - 1)) state_next_s = ST_DONE; else state_next_s = ST_MAC;
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Memory data arriving this cycle belongs to the address issued last cycle.
  always_comb begin
    in_sel_s = {SIZE{1'b0}};
    for (int k = 0; k < IN_SZ; k++) begin
      in_sel_s = (rd_idx_r == IW'(k)) ? in_values[k] : in_sel_s;
    end
    prod_s = in_sel_s * $signed(weight_data);
    if (!rd_valid_r) begin
      acc_next_s = acc_r;
    end else if (rd_idx_r == IW'(IN_SZ)) begin
      acc_next_s = acc_r + ({{(ACC_W - SIZE){weight_data[SIZE-1]}}, weight_data} <<< FRAC);
    end else begin
      acc_next_s = acc_r + {{(ACC_W - 2*SIZE){prod_s[2*SIZE-1]}}, prod_s};
    end
  end

  // Index counters, read pipeline tracking and accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_r        <= {IW{1'b0}};
      o_r        <= {SIZE{1'b0}};
      acc_r      <= {ACC_W{1'b0}};
      rd_valid_r <= 1'b0;
      rd_idx_r   <= {IW{1'b0}};
    end else begin
      rd_valid_r <= (state_r == ST_MAC);
      rd_idx_r   <= i_r;
      case (state_r)
        ST_IDLE: begin
          i_r   <= {IW{1'b0}};
          o_r   <= {SIZE{1'b0}};
          acc_r <= {ACC_W{1'b0}};
        end
        ST_MAC: begin
          i_r   <= i_r + IW'(1);
          acc_r <= acc_next_s;
        end
        ST_DRAIN: acc_r <= acc_next_s;
        ST_WRITE: begin
          i_r   <= {IW{1'b0}};
          acc_r <= {ACC_W{1'b0}};
          o_r   <= (o_r == SIZE'(OUT_SZ - 1)) ? o_r : o_r + SIZE'(1);
        end
        ST_DONE: acc_r <= acc_r;
        default: acc_r <= {ACC_W{1'b0}};
      endcase
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      load_en_r     <= 1'b0;
      load_addr_r   <= {SIZE{1'b0}};
      load_value_r  <= {SIZE{1'b0}};
      weight_addr_r <= {AW{1'b0}};
    end else begin
      busy_r    <= (state_next_s == ST_MAC) || (state_next_s == ST_DRAIN) ||
                   (state_next_s == ST_WRITE);
      done_r    <= (state_next_s == ST_DONE);
      load_en_r <= (state_next_s == ST_WRITE);
      if (state_next_s == ST_WRITE) begin
        load_addr_r  <= o_r;
        load_value_r <= to_out(acc_next_s);
      end
      // Neurons are contiguous in memory, so the address just keeps counting across neurons.
      if (state_next_s == ST_MAC) begin
        weight_addr_r <= (state_r == ST_IDLE) ? {AW{1'b0}} : weight_addr_r + AW'(1);
      end
    end
  end

  assign weight_addr      = weight_addr_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign out_load_en      = load_en_r;
  assign out_load_address = load_addr_r;
  assign out_load_value   = load_value_r;

endmodule

// File: tb/tb_fc_layer_mac.sv
// Scoreboard bench for fc_layer_mac with IN_SZ=4, OUT_SZ=2: directed vectors, expected writes queued, monitor compares.
module tb_fc_layer_mac;
  localparam int SIZE = 16, FRAC = 8, IN_SZ = 4, OUT_SZ = 2, ACC_W = 40;
  localparam int AW = $clog2(OUT_SZ * (IN_SZ + 1));

  logic                       clk = 1'b0;
  logic                       reset, start;
  logic [0:IN_SZ-1][SIZE-1:0] in_values;
  logic [AW-1:0]              weight_addr;
  logic [SIZE-1:0]            weight_data;
  logic                       busy, done, out_load_en;
  logic [SIZE-1:0]            out_load_address, out_load_value;
  logic [SIZE-1:0]            mem [16];

  typedef struct packed { logic [15:0] a; logic [15:0] v; } exp_t;
  exp_t sb[$];
  int   n_vec = 0, n_err = 0, wr_cnt = 0, done_cnt = 0;
  bit   prev_en = 1'b0;

  fc_layer_mac #(.SIZE(SIZE), .FRAC(FRAC), .IN_SZ(IN_SZ), .OUT_SZ(OUT_SZ), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_values(in_values),
    .weight_addr(weight_addr), .weight_data(weight_data), .busy(busy), .done(done),
    .out_load_en(out_load_en), .out_load_address(out_load_address), .out_load_value(out_load_value)
  );

  always #5 clk = ~clk;

  // Synchronous weight memory, one cycle of read latency.
  always @(posedge clk) weight_data <= mem[weight_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard on every write strobe.
  always @(negedge clk) begin
    exp_t e;
    if (out_load_en) begin
      wr_cnt++;
      chk("load_en_back_to_back", {31'd0, prev_en}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_write", {31'd0, out_load_en}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("write_addr", {16'd0, out_load_address}, {16'd0, e.a});
        chk("write_value", {16'd0, out_load_value}, {16'd0, e.v});
      end
    end
    if (done) done_cnt++;
    prev_en = out_load_en;
  end

  task automatic setup(input logic [15:0] inv, input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] w2, input logic [15:0] w3, input logic [15:0] bias);
    for (int k = 0; k < IN_SZ; k++) in_values[k] = inv;
    for (int o = 0; o < OUT_SZ; o++) begin
      mem[o*5+0] = w0; mem[o*5+1] = w1; mem[o*5+2] = w2; mem[o*5+3] = w3; mem[o*5+4] = bias;
    end
  endtask

  task automatic push2(input logic [15:0] v);
    sb.push_back({16'd0, v});
    sb.push_back({16'd1, v});
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_load_en"}, {31'd0, out_load_en}, 32'd0);
    chk({tag, "_load_addr"}, {16'd0, out_load_address}, 32'd0);
    chk({tag, "_load_value"}, {16'd0, out_load_value}, 32'd0);
    chk({tag, "_weight_addr"}, {28'd0, weight_addr}, 32'd0);
  endtask

  // One layer pass; n counts cycles after the start edge.
  task automatic run_pass(input int reset_at, input bit glitch, input bit chk_addr);
    int wr0, dn0;
    bit seen;
    wr0 = wr_cnt; dn0 = done_cnt; seen = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (glitch) start = (n == 5) || (n == 9);
      if (chk_addr && n >= 1 && n <= 5)   chk("weight_addr_n0", {28'd0, weight_addr}, 32'(n - 1));
      if (chk_addr && n >= 8 && n <= 12)  chk("weight_addr_n1", {28'd0, weight_addr}, 32'(n - 3));
      if (n == reset_at) begin
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_zero_outputs("after_reset");
        break;
      end
      if (done) begin
        seen = 1'b1;
        chk("done_cycle", 32'(n), 32'd15);
        chk("busy_in_done", {31'd0, busy}, 32'd0);
        break;
      end
    end
    start = 1'b0;
    if (reset_at == 0) chk("done_seen", {31'd0, seen}, 32'd1);
    repeat (20) @(negedge clk);
    chk("write_count", 32'(wr_cnt - wr0), (reset_at != 0) ? 32'd1 : 32'(OUT_SZ));
    chk("done_count", 32'(done_cnt - dn0), (reset_at != 0) ? 32'd0 : 32'd1);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = 16'd0;
    in_values = '0;
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset_with_start");
    reset = 1'b0;
    start = 1'b0;

    setup(16'd256, 16'd128, 16'd128, 16'd128, 16'd128, 16'd64);
    push2(16'h0240);
    run_pass(0, 1'b0, 1'b0);

    setup(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'd0);
    push2(16'h7FFF);
    run_pass(0, 1'b0, 1'b0);

    setup(16'd256, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'd0);
`ifdef FC_RELU_EN
    push2(16'h0000);
`else
    push2(16'hFC00);
`endif
    run_pass(0, 1'b0, 1'b0);

    setup(16'd256, 16'd0, 16'd256, 16'd512, 16'd768, 16'd0);
    push2(16'd1536);
    run_pass(0, 1'b0, 1'b1);

    setup(16'd256, 16'd128, 16'd128, 16'd128, 16'd128, 16'd64);
    sb.push_back({16'd0, 16'h0240});
    run_pass(10, 1'b0, 1'b0);

    push2(16'h0240);
    run_pass(0, 1'b0, 1'b0);

    push2(16'h0240);
    run_pass(0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
